// File: rtl/bus_pkg.sv
// Shared definitions for the serial-bus master endpoint: FSM encoding,
// default field widths and the slave-select field position.
package bus_pkg;

    localparam int DEF_ADDR_W  = 14;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_BURST_W = 3;

    // Header is address, then the read/write bit, then the burst field.
    localparam int HDR_LEN = DEF_ADDR_W + 1 + DEF_BURST_W;

    localparam int SEL_W   = 2;
    localparam int SEL_MSB = DEF_ADDR_W - 1;
    localparam int SEL_LSB = DEF_ADDR_W - SEL_W;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        ADDR     = 3'd2,
        WAIT_ACK = 3'd3,
        SPLIT    = 3'd4,
        WDATA    = 3'd5,
        RDATA    = 3'd6,
        DONE     = 3'd7
    } state_t;

endpackage

// File: rtl/master_port_if.sv
// Serial shared-bus signals between one master endpoint and the
// arbiter/slave fabric.
interface master_port_if;

    logic request;
    logic grant;
    logic bus_out;
    logic bus_out_valid;
    logic bus_in;
    logic bus_in_valid;
    logic slave_ready;
    logic split;

    modport master (
        output request, bus_out, bus_out_valid,
        input  grant, bus_in, bus_in_valid, slave_ready, split
    );

    modport slave (
        input  request, bus_out, bus_out_valid,
        output grant, bus_in, bus_in_valid, slave_ready, split
    );

endinterface

// File: rtl/master_port_shift_unit.sv
// Parallel-in/serial-out transmit register, serial-in/parallel-out receive
// register and a shared bit counter that wraps after the selected last bit.
module shift_unit #(
    parameter int TX_W  = 18,
    parameter int RX_W  = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_load,
    input  logic [TX_W-1:0]  tx_data,
    input  logic             tx_shift,
    input  logic             rx_en,
    input  logic             rx_bit,
    input  logic             cnt_clear,
    input  logic [CNT_W-1:0] cnt_last,
    output logic             tx_msb,
    output logic [RX_W-1:0]  rx_word,
    output logic             last_bit
);

    logic [TX_W-1:0]  tx_q;
    logic [RX_W-2:0]  rx_q;
    logic [CNT_W-1:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_q    <= '0;
            rx_q    <= '0;
            bit_cnt <= '0;
        end else begin
            if (tx_load)
                tx_q <= tx_data;
            else if (tx_shift)
                tx_q <= {tx_q[TX_W-2:0], 1'b0};

            if (rx_en)
                rx_q <= rx_word[RX_W-2:0];

            if (cnt_clear)
                bit_cnt <= '0;
            else if (tx_shift || rx_en)
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

    // rx_word already includes the bit being sampled, so a full word is
    // available on the same edge that takes its last bit.
    assign tx_msb   = tx_q[TX_W-1];
    assign rx_word  = {rx_q, rx_bit};
    assign last_bit = (bit_cnt == cnt_last);

endmodule

// File: rtl/master_port.sv
// Master endpoint: turns controller commands into serial bus transfers with
// request/grant, header shifting, split release/resume and read capture.
//
//  state    | meaning
//  IDLE     | waiting for enable
//  REQ      | requesting the bus
//  ADDR     | shifting the 18-bit header
//  WAIT_ACK | waiting for slave_ready or split
//  SPLIT    | bus released until split falls
//  WDATA    | shifting write beats
//  RDATA    | collecting read beats from bus_in
//  DONE     | one-cycle completion pulse
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               read_en,
    input  logic [BURST_W-1:0] burst_mode,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [ADDR_W-1:0]  addr_in,
    master_port_if.master      bus,
    output logic               busy,
    output logic [DATA_W-1:0]  data_out,
    output logic               data_out_valid,
    output logic               done,
    output logic               error
);

    localparam int HDR_W = ADDR_W + 1 + BURST_W;
    localparam int CNT_W = $clog2(HDR_W);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    state_t state_q, state_d;

    logic               cmd_rd_q;
    logic [BURST_W-1:0] cmd_burst_q;
    logic [DATA_W-1:0]  cmd_data_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BURST_W-1:0] beat_q;
    logic               hdr_sent_q;
    logic [DATA_W-1:0]  data_out_q;
    logic               dov_q;
    logic               err_q;

    logic               tx_load, tx_shift, rx_en, cnt_clear;
    logic [HDR_W-1:0]   tx_data;
    logic               latch_cmd, set_hdr, beat_adv, capture, abort;
    logic               tx_msb, last_bit;
    logic [DATA_W-1:0]  rx_word;
    logic [CNT_W-1:0]   cnt_last;
    logic [DATA_W-1:0]  beat_data_cur, beat_data_nxt;
    logic [HDR_W-1:0]   header;
    logic               last_beat;

    assign beat_data_cur = cmd_data_q + DATA_W'(beat_q);
    assign beat_data_nxt = beat_data_cur + 1'b1;
    assign header        = {addr_q, cmd_rd_q, cmd_burst_q};
    assign last_beat     = (beat_q == cmd_burst_q);
    assign cnt_last      = (state_q == ADDR) ? HDR_LAST : DATA_LAST;

    always_comb begin
        state_d   = state_q;
        tx_load   = 1'b0;
        tx_data   = {beat_data_cur, {(HDR_W-DATA_W){1'b0}}};
        tx_shift  = 1'b0;
        rx_en     = 1'b0;
        cnt_clear = 1'b0;
        latch_cmd = 1'b0;
        set_hdr   = 1'b0;
        beat_adv  = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    latch_cmd = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (bus.grant) begin
                    cnt_clear = 1'b1;
                    // A resumed split transfer skips straight to its data phase.
                    if (!hdr_sent_q) begin
                        tx_load = 1'b1;
                        tx_data = header;
                        state_d = ADDR;
                    end else if (cmd_rd_q) begin
                        state_d = RDATA;
                    end else begin
                        tx_load = 1'b1;
                        state_d = WDATA;
                    end
                end
            end
            ADDR: begin
                if (!bus.grant) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tx_shift = 1'b1;
                    if (last_bit) begin
                        set_hdr = 1'b1;
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (bus.split) begin
                    state_d = SPLIT;
                end else if (bus.slave_ready) begin
                    cnt_clear = 1'b1;
                    if (cmd_rd_q) begin
                        state_d = RDATA;
                    end else begin
                        tx_load = 1'b1;
                        state_d = WDATA;
                    end
                end
            end
            SPLIT: begin
                if (!bus.split)
                    state_d = REQ;
            end
            WDATA: begin
                if (!bus.grant) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tx_shift = 1'b1;
                    if (last_bit) begin
                        beat_adv = 1'b1;
                        if (last_beat) begin
                            state_d = DONE;
                        end else begin
                            tx_load = 1'b1;
                            tx_data = {beat_data_nxt, {(HDR_W-DATA_W){1'b0}}};
                        end
                    end
                end
            end
            RDATA: begin
                if (!bus.grant) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else if (bus.bus_in_valid) begin
                    rx_en = 1'b1;
                    if (last_bit) begin
                        capture  = 1'b1;
                        beat_adv = 1'b1;
                        if (last_beat)
                            state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cmd_rd_q    <= 1'b0;
            cmd_burst_q <= '0;
            cmd_data_q  <= '0;
            addr_q      <= '0;
            beat_q      <= '0;
            hdr_sent_q  <= 1'b0;
            data_out_q  <= '0;
            dov_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            dov_q   <= capture;
            err_q   <= abort;
            if (latch_cmd) begin
                cmd_rd_q    <= read_en;
                cmd_burst_q <= burst_mode;
                cmd_data_q  <= data_in;
                addr_q      <= addr_in;
                beat_q      <= '0;
                hdr_sent_q  <= 1'b0;
            end
            if (set_hdr)
                hdr_sent_q <= 1'b1;
            if (beat_adv) begin
                beat_q <= beat_q + 1'b1;
                addr_q <= addr_q + 1'b1;
            end
            if (capture)
                data_out_q <= rx_word;
        end
    end

    shift_unit #(
        .TX_W  (HDR_W),
        .RX_W  (DATA_W),
        .CNT_W (CNT_W)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .tx_load   (tx_load),
        .tx_data   (tx_data),
        .tx_shift  (tx_shift),
        .rx_en     (rx_en),
        .rx_bit    (bus.bus_in),
        .cnt_clear (cnt_clear),
        .cnt_last  (cnt_last),
        .tx_msb    (tx_msb),
        .rx_word   (rx_word),
        .last_bit  (last_bit)
    );

    assign bus.request       = (state_q == REQ) || (state_q == ADDR) || (state_q == WAIT_ACK) ||
                               (state_q == WDATA) || (state_q == RDATA);
    assign bus.bus_out_valid = (state_q == ADDR) || (state_q == WDATA);
    assign bus.bus_out       = bus.bus_out_valid & tx_msb;
    assign busy              = (state_q != IDLE);
    assign done              = (state_q == DONE);
    assign data_out          = data_out_q;
    assign data_out_valid    = dov_q;
    assign error             = err_q;

endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: a behavioural arbiter/slave drives commands and the
// expected serial stream / read bytes are checked as they appear.
module tb_master_port;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       read_en = 1'b0;
    logic [2:0] burst_mode = '0;
    logic [7:0] data_in = '0;
    logic [13:0] addr_in = '0;
    logic       busy, data_out_valid, done, error;
    logic [7:0] data_out;

    master_port_if bus ();

    master_port dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .read_en        (read_en),
        .burst_mode     (burst_mode),
        .data_in        (data_in),
        .addr_in        (addr_in),
        .bus            (bus),
        .busy           (busy),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .done           (done),
        .error          (error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit         exp_tx[$];
    logic [7:0] exp_rd[$];
    bit         tx_log[$];
    logic [7:0] rd_log[$];
    logic [7:0] rd_bytes[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_request"}, 32'(bus.request), 0);
        check({tag, "_bus_out"}, 32'(bus.bus_out), 0);
        check({tag, "_bus_out_valid"}, 32'(bus.bus_out_valid), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_data_out"}, 32'(data_out), 0);
        check({tag, "_data_out_valid"}, 32'(data_out_valid), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_error"}, 32'(error), 0);
    endtask

    function automatic logic [31:0] tx_slice(input int from, input int n);
        logic [31:0] r = '0;
        for (int i = from; i < from + n; i++)
            r = {r[30:0], (i < tx_log.size()) ? tx_log[i] : 1'b0};
        return r;
    endfunction

    // Compare process: every transmitted bit and every read beat against the model.
    always @(negedge clk) begin
        if (bus.bus_out_valid) begin
            tx_log.push_back(bus.bus_out);
            check("tx_pending", 32'(exp_tx.size() != 0), 1);
            if (exp_tx.size() != 0)
                check("tx_bit", 32'(bus.bus_out), 32'(exp_tx.pop_front()));
        end
        if (data_out_valid) begin
            rd_log.push_back(data_out);
            check("rd_pending", 32'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0)
                check("rd_data", 32'(data_out), 32'(exp_rd.pop_front()));
        end
        if (done)  done_cnt++;
        if (error) err_cnt++;
    end

    task automatic run_cmd(input bit rw, input logic [2:0] b, input logic [7:0] d,
                           input logic [13:0] a, input int split_len, input int drop_bit,
                           input int rst_bit, input bit fast, output int done_cyc,
                           output int split_req_low, output int req_after_split);
        int cyc, bits_seen, rd_sent, split_left, rst_cyc, nbits_rd, done0, err0;
        bit acked, rd_go, started, finished, gnt_prev;
        logic [17:0] hdr;
        logic [7:0]  v;
        cyc = 0; bits_seen = 0; rd_sent = 0; split_left = 0; rst_cyc = -1;
        acked = 0; rd_go = 0; started = 0; finished = 0;
        done_cyc = -1; split_req_low = 0; req_after_split = 0;
        nbits_rd = 8 * (int'(b) + 1);
        done0 = done_cnt; err0 = err_cnt;

        hdr = {a, rw, b};
        exp_tx.delete(); exp_rd.delete(); tx_log.delete(); rd_log.delete();
        for (int i = 0; i < 18; i++)
            if (drop_bit < 0 || i <= drop_bit) exp_tx.push_back(hdr[17-i]);
        if (drop_bit < 0 && !rw)
            for (int k = 0; k <= int'(b); k++) begin
                v = d + 8'(k);
                for (int j = 7; j >= 0; j--) exp_tx.push_back(v[j]);
            end
        if (drop_bit < 0 && rw && rst_bit < 0)
            for (int k = 0; k <= int'(b); k++) exp_rd.push_back(rd_bytes[k]);

        @(negedge clk);
        read_en = rw; burst_mode = b; data_in = d; addr_in = a; enable = 1'b1;

        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            gnt_prev = bus.grant;
            if (bus.bus_out_valid) bits_seen++;
            if (done && done_cyc < 0) done_cyc = cyc;
            if (bus.split && !bus.request) split_req_low++;
            if (acked && split_len > 0 && !bus.split && bus.request) req_after_split++;
            if (rst_cyc >= 0 && cyc == rst_cyc + 1) check_all_zero("after_reset");
            if (busy) started = 1;
            if (started && !busy) begin
                finished = 1;
                break;
            end

            reset = 1'b1;
            enable = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            if (enable) begin
                read_en = 1'($urandom); burst_mode = 3'($urandom);
                data_in = 8'($urandom); addr_in = 14'($urandom);
            end

            if (drop_bit >= 0 && bits_seen == drop_bit + 1) bus.grant = 1'b0;
            else if (!bus.request) bus.grant = 1'b0;
            else if (!bus.grant) bus.grant = fast || ($urandom_range(0, 2) == 0);

            if (rw && acked && bus.request && gnt_prev) rd_go = 1;

            bus.slave_ready = 1'b0;
            if (!acked && bits_seen >= 18 && !bus.bus_out_valid && (fast || $urandom_range(0, 1) == 1)) begin
                acked = 1;
                if (split_len > 0) begin
                    bus.split = 1'b1;
                    split_left = split_len;
                end else begin
                    bus.slave_ready = 1'b1;
                end
            end else if (split_left > 0) begin
                split_left--;
                if (split_left == 0) bus.split = 1'b0;
            end

            bus.bus_in_valid = 1'b0;
            if (rd_go && rd_sent < nbits_rd) begin
                if (rst_bit >= 0 && rd_sent == rst_bit && rst_cyc < 0) begin
                    reset = 1'b0;
                    rst_cyc = cyc;
                end else if (fast || $urandom_range(0, 1) == 1) begin
                    bus.bus_in_valid = 1'b1;
                    bus.bus_in = rd_bytes[rd_sent/8][7 - (rd_sent % 8)];
                    rd_sent++;
                end
            end
        end
        check("cmd_completes", 32'(finished), 1);

        enable = 1'b0; reset = 1'b1;
        bus.grant = 1'b0; bus.slave_ready = 1'b0; bus.split = 1'b0;
        bus.bus_in_valid = 1'b0; bus.bus_in = 1'b0;
        repeat (2) @(negedge clk);

        check("tx_remaining", 32'(exp_tx.size()), 0);
        check("rd_remaining", 32'(exp_rd.size()), 0);
        check("done_count", 32'(done_cnt - done0), (drop_bit < 0 && rst_bit < 0) ? 1 : 0);
        check("error_count", 32'(err_cnt - err0), (drop_bit >= 0) ? 1 : 0);
        check("busy_after", 32'(busy), 0);
        check("request_after", 32'(bus.request), 0);
    endtask

    initial begin
        int dc, sl, ra, splen;
        bit rw;
        logic [2:0] b;
        bus.grant = 1'b0; bus.slave_ready = 1'b0; bus.split = 1'b0;
        bus.bus_in = 1'b0; bus.bus_in_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        // Single write, immediate grant and ready.
        run_cmd(0, 3'd0, 8'b10101010, 14'b01010101010101, 0, -1, -1, 1, dc, sl, ra);
        check("t1_done_cycle", 32'(dc), 29);
        check("t1_bit_count", 32'(tx_log.size()), 26);
        check("t1_stream", tx_slice(0, 26), 32'b01010101010101_0_000_10101010);

        // Burst read with gaps on bus_in_valid.
        rd_bytes[0] = 8'h5A; rd_bytes[1] = 8'hC3;
        run_cmd(1, 3'd1, 8'h00, 14'd5012, 0, -1, -1, 0, dc, sl, ra);
        check("t2_beats", 32'(rd_log.size()), 2);
        check("t2_beat0", 32'(rd_log[0]), 32'h5A);
        check("t2_beat1", 32'(rd_log[1]), 32'hC3);

        // Reset during RDATA; data_out still holds C3 going in.
        rd_bytes[0] = 8'h96; rd_bytes[1] = 8'h3C; rd_bytes[2] = 8'h11;
        run_cmd(1, 3'd2, 8'h00, 14'h1234, 0, -1, 3, 1, dc, sl, ra);
        check("t6_no_data", 32'(rd_log.size()), 0);

        // Split write.
        run_cmd(0, 3'd0, 8'd78, 14'd5012, 8, -1, -1, 1, dc, sl, ra);
        check("t3_bit_count", 32'(tx_log.size()), 26);
        check("t3_data", tx_slice(18, 8), 32'b01001110);
        check("t3_req_low_in_split", 32'(sl), 8);
        check("t3_req_resumed", 32'(ra > 0), 1);

        // Burst wrap of write data.
        run_cmd(0, 3'd2, 8'hFE, 14'h3FFF, 0, -1, -1, 1, dc, sl, ra);
        check("t4_bit_count", 32'(tx_log.size()), 42);
        check("t4_beats", tx_slice(18, 24), 32'hFEFF00);

        // Grant loss at header bit 5.
        run_cmd(0, 3'd3, 8'h33, 14'h2AAA, 0, 5, -1, 1, dc, sl, ra);
        check("t5_bit_count", 32'(tx_log.size()), 6);
        check("t5_no_done", 32'(dc < 0), 1);

        for (int n = 0; n < 40; n++) begin
            rw = 1'($urandom);
            b = 3'($urandom);
            splen = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
            for (int k = 0; k < 8; k++) rd_bytes[k] = 8'($urandom);
            run_cmd(rw, b, 8'($urandom), 14'($urandom), splen, -1, -1, 0, dc, sl, ra);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/master_port.md
Name: master_port

Overview:
- Master-side endpoint of the stimulus command interface: consumes enable/read_en/burst_mode/data_in/addr_in commands issued by the test controller and executes them on the serial shared bus.
- Handles bus request/grant, serial address/data shifting, read-data capture and split-transaction release/resume.
- One instance per master (m1, m2). Sits between the controller and the arbiter/slave fabric.

Parameters:
- ADDR_W, 14, address width; the top 2 bits are the slave select.
- DATA_W, 8, data width.
- BURST_W, 3, burst field width; beat count = burst_mode + 1.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- enable  in  1  command strobe; sampled only in IDLE
- read_en  in  1  1=read, 0=write
- burst_mode  in  BURST_W  beats-1
- data_in  in  DATA_W  write data for beat 0
- addr_in  in  ADDR_W  start address
- request  out  1  bus request to arbiter
- grant  in  1  arbiter grant
- bus_out  out  1  serial tx bit
- bus_out_valid  out  1  qualifies bus_out
- bus_in  in  1  serial rx bit (read data)
- bus_in_valid  in  1  qualifies bus_in
- slave_ready  in  1  slave accepted address phase
- split  in  1  slave requests split (release bus)
- busy  out  1  command in progress
- data_out  out  DATA_W  last read beat
- data_out_valid  out  1  one-cycle pulse per read beat
- done  out  1  one-cycle pulse at command completion
- error  out  1  one-cycle pulse on grant loss mid-transfer

Behaviour:
- Reset (reset=0 at clk edge): state=IDLE. All outputs 0; internal registers, beat counter and bit counter cleared. Reset aborts any transfer in the same cycle.
- IDLE:
  - enable=1 latches read_en, burst_mode, data_in and addr_in into command registers; next state is REQ and busy=1 from the next cycle.
  - enable in any other state is ignored.
- REQ: request=1. On grant=1, go to ADDR with bit counter=0.
- ADDR:
  - Shifts an 18-bit header MSB first, one bit per cycle with bus_out_valid=1: addr[13:0], rw bit (1=read), then burst[2:0].
  - After bit 17 goes to WAIT_ACK.
- WAIT_ACK:
  - bus_out_valid=0.
  - slave_ready=1 goes to WDATA (write) or RDATA (read).
  - split=1 goes to SPLIT. split takes priority if asserted together with slave_ready.
- SPLIT:
  - request=0 and the bus is released; busy stays 1.
  - When split falls to 0, go to REQ.
  - On re-grant, go directly to WDATA/RDATA with no header resend. A flag records that the header was already sent.
- WDATA:
  - Shifts 8 bits MSB first with bus_out_valid=1.
  - Beat k data = latched data_in + k, modulo 2^8, wrapping 8'hFF to 8'h00.
  - After each beat the internal address increments by 1, modulo 2^14.
  - After the last beat go to DONE.
- RDATA:
  - Samples bus_in on cycles with bus_in_valid=1, shifting MSB first.
  - After 8 valid bits: data_out updates and data_out_valid pulses on the next cycle.
  - Beats continue until burst_mode+1 beats are received, then go to DONE.
- DONE:
  - done pulses for 1 cycle and request=0.
  - Next cycle: state IDLE, busy=0.
- Grant loss:
  - Applies when grant=0 in ADDR, WDATA or RDATA.
  - error pulses, request=0, go to IDLE.
  - Command is discarded; no done pulse.
- Latency: single-beat write with grant and slave_ready immediate:
  - enable→request: 1 cycle.
  - Full header plus data: 18+1+8 cycles.
  - done asserts 29 cycles after enable.
- Timing: request deasserts in the same cycle DONE is entered. Arbiter may re-grant another master next cycle.

Decomposition:
- Shared package bus_pkg holds:
  - state encoding: IDLE, REQ, ADDR, WAIT_ACK, SPLIT, WDATA, RDATA, DONE.
  - HDR_LEN=18.
  - ADDR_W, DATA_W and BURST_W defaults.
  - Slave-select field position.
- One sub-module, shift_unit, provides a loadable parallel-in/serial-out register plus a serial-in/parallel-out register with bit counter and last-bit flag. The FSM stays in master_port.

Test Plan:
- Single write:
  - Stimulus: enable, read_en=0, burst=0, data=8'b10101010, addr=14'b01010101010101; grant and slave_ready held 1.
  - Required: bus_out header = 01010101010101,0,000; data = 10101010; done at cycle 29; busy low after.
- Burst read:
  - Stimulus: burst=1, addr=14'd5012; slave drives 8'h5A then 8'hC3 on bus_in with gaps in bus_in_valid.
  - Required: data_out_valid pulses twice with 5A then C3; done once.
- Split write:
  - Stimulus: data=8'd78, addr=14'd5012; split=1 for 8 cycles after the header.
  - Required: request drops during split, re-asserts after; header not resent; data 01001110 sent once; done.
- Burst wrap:
  - Stimulus: burst=2, data=8'hFE, addr=14'h3FFF.
  - Required: beats FE, FF, 00.
- Grant loss:
  - Stimulus: grant drops at header bit 5.
  - Required: error pulse, back to IDLE, no done; enable while busy is ignored.
- Reset mid-RDATA:
  - Stimulus: reset=0 for one cycle during RDATA.
  - Required: all outputs 0 next cycle, state IDLE.
